// File: rtl/config_write_arbiter.sv
// Round-robin arbiter and read-modify-write sequencer for the single write
// port of the shared configuration memory.
module config_write_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 35
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ*DW-1:0]   req_mask,
    input  logic [DW-1:0]        mem_out,
    output logic [DW-1:0]        mem_in,
    output logic                 mem_wren,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     win;
    logic [IW-1:0]     cand;
    logic              found;
    logic [DW-1:0]     data_w, mask_w;
    logic [DW-1:0]     mem_in_d;
    logic              wren_d;
    logic [NREQ-1:0]   ack_d;
    int unsigned       j;

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        j     = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            cand = IW'(j);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign data_w = req_data[32'(win)*DW +: DW];
    assign mask_w = req_mask[32'(win)*DW +: DW];

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        mem_in_d = mem_in;
        wren_d   = 1'b0;
        ack_d    = '0;
        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    idx_d    = win;
                    mem_in_d = (mem_out & ~mask_w) | (data_w & mask_w);
                    wren_d   = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                ack_d[idx_q] = 1'b1;
                state_d      = ACK;
            end
            ACK: begin
                if (32'(idx_q) + 1 >= NREQ) ptr_d = '0;
                else                        ptr_d = IW'(32'(idx_q) + 1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            mem_in   <= '0;
            mem_wren <= 1'b0;
            ack      <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            mem_in   <= mem_in_d;
            mem_wren <= wren_d;
            ack      <= ack_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_config_write_arbiter.sv
// Directed bench for config_write_arbiter with a cycle-timestamp reference
// model checked every cycle, plus literal expectations per scenario.
module tb_config_write_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned DW   = 35;

    logic                 clk = 1'b0;
    logic                 arst = 1'b0;
    logic                 enable = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ*DW-1:0]   req_mask = '0;
    logic [DW-1:0]        mem_out;
    logic [DW-1:0]        mem_in;
    logic                 mem_wren;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic [1:0]           dbg_state;

    config_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .arst(arst), .enable(enable), .req(req),
        .req_data(req_data), .req_mask(req_mask), .mem_out(mem_out),
        .mem_in(mem_in), .mem_wren(mem_wren), .ack(ack), .busy(busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory stand-in: registered storage, with a bench-side preload port.
    logic [DW-1:0] mem = '0;
    logic          mem_load = 1'b0;
    logic [DW-1:0] mem_load_val = '0;
    assign mem_out = mem;
    always @(posedge clk) begin
        if (mem_load)      mem <= mem_load_val;
        else if (mem_wren) mem <= mem_in;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant at the end of cycle g means write in g+1,
    // ack in g+2, and the next grant can be made at the end of g+3.
    int            cyc = 0;
    int            g_cyc = -100;
    int            w_m = 0;
    int            ptr_m = 0;
    int            jm;
    logic          fm;
    logic [DW-1:0] exp_mi = '0;
    logic [DW-1:0] dm, mm;

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            cyc = 0; g_cyc = -100; w_m = 0; ptr_m = 0; exp_mi = '0;
        end else begin
            if (cyc >= g_cyc + 3 && enable && req != '0) begin
                fm = 1'b0;
                for (int k = 0; k < int'(NREQ); k++) begin
                    jm = (ptr_m + k) % int'(NREQ);
                    if (!fm && req[jm]) begin
                        fm  = 1'b1;
                        w_m = jm;
                    end
                end
                dm     = req_data[w_m*DW +: DW];
                mm     = req_mask[w_m*DW +: DW];
                exp_mi = (mem & ~mm) | (dm & mm);
                ptr_m  = (w_m + 1) % int'(NREQ);
                g_cyc  = cyc;
            end
            cyc++;
        end
    end

    logic            e_wren, e_busy;
    logic [NREQ-1:0] e_ack;
    logic [1:0]      e_st;

    always @(negedge clk) begin
        e_wren = arst && (cyc == g_cyc + 1);
        e_ack  = (arst && cyc == g_cyc + 2) ? NREQ'(1 << w_m) : '0;
        e_busy = arst && (cyc == g_cyc + 1 || cyc == g_cyc + 2);
        e_st   = !arst ? 2'd0 : (cyc == g_cyc + 1) ? 2'd1 : (cyc == g_cyc + 2) ? 2'd2 : 2'd0;
        check("cyc_wren",  64'(mem_wren),  64'(e_wren));
        check("cyc_ack",   64'(ack),       64'(e_ack));
        check("cyc_busy",  64'(busy),      64'(e_busy));
        check("cyc_state", 64'(dbg_state), 64'(e_st));
        check("cyc_memin", 64'(mem_in),    64'(exp_mi));
    end

    task automatic set_mem(input logic [DW-1:0] v);
        mem_load = 1'b1; mem_load_val = v;
        @(negedge clk);
        mem_load = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_data[i*DW +: DW] = d;
        req_mask[i*DW +: DW] = m;
    endtask

    task automatic wait_wren(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (mem_wren !== 1'b1 && n < 8);
        check(name, 64'(mem_wren), 64'd1);
    endtask

    task automatic wait_ack(input string name, input logic [NREQ-1:0] exp);
        int n = 0;
        do begin @(negedge clk); n++; end while (ack === '0 && n < 8);
        check(name, 64'(ack), 64'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk); #2 arst = 1'b0;
        @(negedge clk); #2 arst = 1'b1;
    endtask

    logic [NREQ-1:0] rr_exp [4];
    time             t_prev, t_now;

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wren",  64'(mem_wren), 64'd0);
        check("rst_ack",   64'(ack), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_memin", 64'(mem_in), 64'd0);
        #2 arst = 1'b1;
        enable = 1'b1;

        // Single write
        @(negedge clk);
        set_mem(35'h0);
        set_req(0, 35'h0_0000_00AB, 35'h0_0000_00FF);
        req = 3'b001;
        @(negedge clk);
        check("t1_wren",  64'(mem_wren), 64'd1);
        check("t1_memin", 64'(mem_in), 64'h0AB);
        check("t1_busy_w", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_ack",   64'(ack), 64'b001);
        check("t1_wren_off", 64'(mem_wren), 64'd0);
        check("t1_busy_a", 64'(busy), 64'd1);
        req = 3'b000;
        @(negedge clk);
        check("t1_idle_busy", 64'(busy), 64'd0);
        check("t1_idle_ack",  64'(ack), 64'd0);
        check("t1_mem", 64'(mem_out), 64'h0AB);

        // Masked merge on the lenght field
        set_mem(35'h7_FFFF_FFFF);
        set_req(1, 35'h0, 35'h0_00F0_0000);
        req = 3'b010;
        wait_wren("t2_wren");
        check("t2_memin", 64'(mem_in), 64'h7_FF0F_FFFF);
        wait_ack("t2_ack", 3'b010);
        req = 3'b000;
        @(negedge clk);

        // Round-robin with all requesters continuously asking
        do_reset();
        set_req(0, 35'h0_0000_0011, 35'h7_FFFF_FFFF);
        set_req(1, 35'h0_0000_0022, 35'h7_FFFF_FFFF);
        set_req(2, 35'h0_0000_0033, 35'h7_FFFF_FFFF);
        req = 3'b111;
        t_prev = 0;
        for (int a = 0; a < 4; a++) begin
            wait_ack("rr_ack", rr_exp[a]);
            t_now = $time;
            if (a > 0) check("rr_gap", 64'(t_now - t_prev), 64'd30);
            t_prev = t_now;
        end
        req = 3'b000;
        repeat (2) @(negedge clk);

        // enable gating
        enable = 1'b0;
        set_req(1, 35'h0_0000_5A00, 35'h0_0000_FF00);
        req = 3'b010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("en_blocked", 64'(mem_wren), 64'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("en_grant", 64'(mem_wren), 64'd1);
        enable = 1'b0;
        @(negedge clk);
        check("en_drop_ack", 64'(ack), 64'b010);
        req = 3'b000;
        @(negedge clk);
        enable = 1'b1;

        // Reset in the WRITE cycle
        set_req(0, 35'h0_0000_0077, 35'h0_0000_00FF);
        req = 3'b001;
        wait_wren("rm_wren");
        #2 arst = 1'b0;
        #1 check("rm_async_wren", 64'(mem_wren), 64'd0);
        check("rm_async_state", 64'(dbg_state), 64'd0);
        set_req(1, 35'h0_0000_0100, 35'h0_0000_0F00);
        set_req(2, 35'h0_0000_2000, 35'h0_0000_F000);
        req = 3'b110;
        @(negedge clk);
        check("rm_no_ack", 64'(ack), 64'd0);
        #2 arst = 1'b1;
        wait_ack("rm_first", 3'b010);
        req = 3'b000;
        repeat (2) @(negedge clk);

        // Zero mask, then a data change during WRITE
        set_mem(35'h1_2345_6789);
        set_req(2, 35'h5_5555_5555, 35'h0);
        req = 3'b100;
        wait_wren("zm_wren");
        check("zm_memin", 64'(mem_in), 64'h1_2345_6789);
        set_req(2, 35'h0_0F0F_0F0F, 35'h7_FFFF_FFFF);
        @(negedge clk);
        check("zm_hold", 64'(mem_in), 64'h1_2345_6789);
        check("zm_ack", 64'(ack), 64'b100);
        req = 3'b000;
        repeat (3) @(negedge clk);
        check("zm_mem", 64'(mem_out), 64'h1_2345_6789);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/config_write_arbiter.md
# config_write_arbiter

Round-robin arbiter and read-modify-write sequencer for the single write port of the shared 35-bit configuration memory. The memory word holds the subsystem settings: tc_ref[7:0], chs_conf[15:8], ulight[19:16], lenght[23:20], dance_pdata[31:24], dance_din[32] and syskey[34:33]. Up to NREQ requesters (control unit, remote/serial config path, safety override) each supply a word and a bit mask. Only the masked fields are rewritten; all other fields are preserved. The block sits between the requesters and the memory, and is the only driver of mem_in and mem_wren.

## Interface
- NREQ, 3, number of requesters, legal range 2..4
- DW, 35, memory word width
- clk  in  1  clock, all state changes on rising edge
- arst  in  1  asynchronous, active-low reset
- enable  in  1  high permits new grants; low blocks new grants while an in-flight transaction completes
- req  in  NREQ  per-requester level request
- req_data  in  NREQ*DW  requester i's word at bits [i*DW +: DW]
- req_mask  in  NREQ*DW  requester i's mask at bits [i*DW +: DW]; 1 = overwrite this bit
- mem_out  in  DW  current memory contents, registered output of the memory
- mem_in  out  DW  merged word to be written
- mem_wren  out  1  memory write enable; the memory captures mem_in on the edge ending a cycle with wren=1
- ack  out  NREQ  one-hot, one-cycle completion pulse
- busy  out  1  transaction in flight
- dbg_state  out  2  FSM encoding: IDLE=0, WRITE=1, ACK=2

## Operation
- States are IDLE, WRITE and ACK; encoding 3 is unused and recovers to IDLE.
- IDLE:
  - If enable=1 and req≠0, select the winner by round-robin.
  - The search starts at pointer ptr and proceeds ptr, ptr+1, … mod NREQ; the first set bit wins.
  - On that edge, register idx = winner.
  - On that edge, register mem_in = (mem_out & ~mask_w) | (data_w & mask_w), using the winner's data_w and mask_w.
  - On that edge, set mem_wren=1 and go to WRITE.
  - Otherwise stay in IDLE with mem_wren=0.
- WRITE:
  - mem_wren=1 and mem_in held for exactly one cycle.
  - Next edge: mem_wren←0, ack[idx]←1, go to ACK.
- ACK:
  - ack[idx]=1 for exactly one cycle; mem_out now reflects the new word.
  - Next edge: ack←0, ptr←(idx+1) mod NREQ, go to IDLE unconditionally. req is not sampled in this state.
- Requester rule:
  - Hold req, req_data and req_mask stable from assertion until ack is seen.
  - Deassert req no later than the cycle after ack. A registered response to ack meets this.
  - A req still high in IDLE after its ack counts as a new request.
- Data and mask are sampled only at the IDLE→WRITE edge. Changes afterwards do not affect the in-flight write.
- mask = 0 is still a full transaction: the unchanged word is written and ack is issued.
- Deasserting enable does not abort WRITE or ACK.
- Deasserting req before ack is a protocol violation; the in-flight write still completes and acks.
- busy = (state≠IDLE).
- All outputs are registered; there is no combinational path from req to any output.
- Reset (arst=0, async, at any time including mid-WRITE):
  - state=IDLE, ptr=0, idx=0.
  - mem_wren=0, mem_in=0, ack=0, busy=0, dbg_state=0.
  - An interrupted transaction is dropped without ack. The requester must re-request.

## Timing
- Cycle k: req sampled high at the end of IDLE.
- Cycle k+1: WRITE, mem_wren=1.
- Cycle k+2: ACK.
- Cycle k+3: IDLE.
- A request waits at most (NREQ-1) transactions plus 3 cycles.
- Peak throughput: one write per 3 cycles when a requester is always waiting.
- Simultaneous requests are resolved by ptr only; with ptr=0 and all three requesting, the grant order is 0,1,2,0,…
- Recovery from reset: the first sampling edge is the first rising edge after arst deasserts.

## Test plan
- Reset then single write.
  - Stimulus: reset; mem=0; req=001, data0=0x0_0000_00AB, mask0=0x0_0000_00FF.
  - Response: wren high one cycle with mem_in=0x0_0000_00AB; ack=001 two cycles after sampling; busy high 2 cycles.
- Masked merge.
  - Stimulus: mem=0x7_FFFF_FFFF; req1 with data=0, mask=0x0_00F0_0000 (lenght field).
  - Response: mem_in=0x7_FF0F_FFFF.
- Round-robin fairness.
  - Stimulus: req=111 held, each requester re-requesting immediately after its ack.
  - Response: ack sequence 001,010,100,001, each 3 cycles apart.
- enable gating.
  - Stimulus: enable=0 with req=010.
  - Response: no wren for 10 cycles.
  - Stimulus: raise enable.
  - Response: grant on the next edge.
  - Stimulus: drop enable during WRITE.
  - Response: the write and ack still complete.
- Reset mid-transaction.
  - Stimulus: assert arst=0 in the WRITE cycle.
  - Response: mem_wren falls immediately (async); ack never pulses; ptr returns to 0. After release with req=110, requester 1 wins first.
- Zero mask and late data change.
  - Stimulus: mask=0 on mem=0x1_2345_6789.
  - Response: mem_in=0x1_2345_6789 and an ack is issued.
  - Stimulus: change req_data during WRITE.
  - Response: mem_in unchanged.
